// File: rtl/pool_window_scheduler.sv
// Beat counter and strobe generator for a 2x2 max-pooling line-buffer datapath.
// Optional stall statistics output enabled by defining POOL_SCHED_STALL_CNT_EN.
module pool_window_scheduler #(
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int CNT_W  = 5,
    parameter int ADDR_W = 4
) (
    input  logic              S_AXIS_ACLK,
    input  logic              S_AXIS_ARESET,
    input  logic              Start,
    input  logic              S_AXIS_TVALID,
    output logic              S_AXIS_TREADY,
    input  logic              M_READY,
    output logic              Pix_Phase,
    output logic              Lbuf_Wr_En,
    output logic              Lbuf_Rd_En,
    output logic [ADDR_W-1:0] Lbuf_Addr,
    output logic              Win_Valid,
    output logic              Busy,
    output logic              Frame_Done,
`ifdef POOL_SCHED_STALL_CNT_EN
    output logic [15:0]       Stall_Cnt,
`endif
    output logic [CNT_W-1:0]  Col,
    output logic [CNT_W-1:0]  Row
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVEN = 2'd1;
    localparam logic [1:0] S_ODD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
    localparam bit               ODD_H    = (IMG_H % 2) == 1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             win_valid_q, win_valid_d;
    logic             tready;
    logic             beat;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        tready  = (state_q == S_EVEN) || ((state_q == S_ODD) && M_READY);
        beat    = S_AXIS_TVALID && tready;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_EVEN;
                end
            end
            S_EVEN, S_ODD: begin
                if (beat) begin
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + CNT_W'(1);
                            state_d = row_d[0] ? S_ODD : S_EVEN;
                        end
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The unpaired last row of an odd-height frame has no partner to read it back.
        wr_en = beat && (state_q == S_EVEN) && col_q[0] && !(ODD_H && (row_q == LAST_ROW));
        rd_en = beat && (state_q == S_ODD) && col_q[0];
        win_valid_d = rd_en;
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
        end
    end

`ifdef POOL_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && Start) begin
            stall_cnt_d = '0;
        end else if ((state_q == S_ODD) && S_AXIS_TVALID && !M_READY && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
`endif

    assign S_AXIS_TREADY = tready;
    assign Pix_Phase     = col_q[0];
    assign Lbuf_Wr_En    = wr_en;
    assign Lbuf_Rd_En    = rd_en;
    assign Lbuf_Addr     = ADDR_W'(col_q >> 1);
    assign Win_Valid     = win_valid_q;
    assign Busy          = (state_q != S_IDLE);
    assign Frame_Done    = (state_q == S_DONE);
    assign Col           = col_q;
    assign Row           = row_q;

endmodule

// File: tb/tb_pool_window_scheduler.sv
// Scoreboard bench: a 4x4 and a 5x3 scheduler share one stimulus stream and are
// compared against a pixel-index reference model; window pulses go through a queue.
module tb_pool_window_scheduler;

    localparam int NDUT = 2;

    typedef struct packed {
        int dut;
        int cyc;
    } win_event_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic tvalid = 1'b0;
    logic mready = 1'b0;

    logic       treadyO [NDUT];
    logic       phaseO  [NDUT];
    logic       wrO     [NDUT];
    logic       rdO     [NDUT];
    logic [3:0] addrO   [NDUT];
    logic       winO    [NDUT];
    logic       busyO   [NDUT];
    logic       doneO   [NDUT];
    logic [4:0] colO    [NDUT];
    logic [4:0] rowO    [NDUT];
`ifdef POOL_SCHED_STALL_CNT_EN
    logic [15:0] stallO [NDUT];
`endif

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    bit mActive [NDUT];
    bit mDone   [NDUT];
    int mIdx    [NDUT];
    int mStall  [NDUT];
    bit eTready [NDUT];
    bit eBeat   [NDUT];
    bit eWr     [NDUT];
    bit eRd     [NDUT];
    int eCol    [NDUT];
    int eRow    [NDUT];

    win_event_t winQ [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pool_window_scheduler #(.IMG_W(4), .IMG_H(4), .CNT_W(5), .ADDR_W(4)) dut_a (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .Start(start),
        .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(treadyO[0]), .M_READY(mready),
        .Pix_Phase(phaseO[0]), .Lbuf_Wr_En(wrO[0]), .Lbuf_Rd_En(rdO[0]),
        .Lbuf_Addr(addrO[0]), .Win_Valid(winO[0]), .Busy(busyO[0]),
        .Frame_Done(doneO[0]),
`ifdef POOL_SCHED_STALL_CNT_EN
        .Stall_Cnt(stallO[0]),
`endif
        .Col(colO[0]), .Row(rowO[0])
    );

    pool_window_scheduler #(.IMG_W(5), .IMG_H(3), .CNT_W(5), .ADDR_W(4)) dut_b (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .Start(start),
        .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(treadyO[1]), .M_READY(mready),
        .Pix_Phase(phaseO[1]), .Lbuf_Wr_En(wrO[1]), .Lbuf_Rd_En(rdO[1]),
        .Lbuf_Addr(addrO[1]), .Win_Valid(winO[1]), .Busy(busyO[1]),
        .Frame_Done(doneO[1]),
`ifdef POOL_SCHED_STALL_CNT_EN
        .Stall_Cnt(stallO[1]),
`endif
        .Col(colO[1]), .Row(rowO[1])
    );

    function automatic int imgW(input int i);
        return (i == 0) ? 4 : 5;
    endfunction

    function automatic int imgH(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    task automatic compareValue(input string name, input int i, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, i, cyc, actual, expected);
        end
    endtask

    // Window pulses are matched against the cycle the model predicted for them.
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (winO[i]) begin
                int idx;
                idx = -1;
                for (int j = 0; j < winQ.size(); j++) begin
                    if (winQ[j].dut == i) begin
                        idx = j;
                        break;
                    end
                end
                if (idx < 0) begin
                    compareValue("win_valid_unexpected", i, 1, 0);
                end else begin
                    compareValue("win_valid_cycle", i, cyc, winQ[idx].cyc);
                    winQ.delete(idx);
                end
            end
        end
        for (int j = winQ.size() - 1; j >= 0; j--) begin
            if (winQ[j].cyc < cyc) begin
                compareValue("win_valid_missing", winQ[j].dut, 0, 1);
                winQ.delete(j);
            end
        end
    end

    task automatic computeExpected(input int i);
        int w;
        int h;
        w = imgW(i);
        h = imgH(i);
        if (rst) begin
            mActive[i] = 1'b0;
            mDone[i]   = 1'b0;
            mIdx[i]    = 0;
            mStall[i]  = 0;
        end
        eRow[i]    = mIdx[i] / w;
        eCol[i]    = mIdx[i] % w;
        eTready[i] = mActive[i] && ((eRow[i] % 2 == 0) || mready);
        eBeat[i]   = eTready[i] && tvalid;
        eWr[i]     = eBeat[i] && (eRow[i] % 2 == 0) && (eCol[i] % 2 == 1) && (eRow[i] + 1 < h);
        eRd[i]     = eBeat[i] && (eRow[i] % 2 == 1) && (eCol[i] % 2 == 1);
    endtask

    task automatic checkOutput(input int i);
        compareValue("tready", i, int'(treadyO[i]), int'(eTready[i]));
        compareValue("lbuf_wr_en", i, int'(wrO[i]), int'(eWr[i]));
        compareValue("lbuf_rd_en", i, int'(rdO[i]), int'(eRd[i]));
        compareValue("lbuf_addr", i, int'(addrO[i]), eCol[i] / 2);
        compareValue("pix_phase", i, int'(phaseO[i]), eCol[i] % 2);
        compareValue("col", i, int'(colO[i]), eCol[i]);
        compareValue("row", i, int'(rowO[i]), eRow[i]);
        compareValue("busy", i, int'(busyO[i]), int'(mActive[i] || mDone[i]));
        compareValue("frame_done", i, int'(doneO[i]), int'(mDone[i]));
`ifdef POOL_SCHED_STALL_CNT_EN
        compareValue("stall_cnt", i, int'(stallO[i]), mStall[i]);
`endif
    endtask

    task automatic advanceModel(input int i);
        if (rst) return;
        if (mDone[i]) begin
            mDone[i] = 1'b0;
        end else if (mActive[i]) begin
            if ((eRow[i] % 2 == 1) && tvalid && !mready && mStall[i] < 65535) mStall[i]++;
            if (eBeat[i]) begin
                if (eRd[i]) winQ.push_back('{dut: i, cyc: cyc + 1});
                mIdx[i]++;
                if (mIdx[i] == imgW(i) * imgH(i)) begin
                    mIdx[i]    = 0;
                    mActive[i] = 1'b0;
                    mDone[i]   = 1'b1;
                end
            end
        end else if (start) begin
            mActive[i] = 1'b1;
            mStall[i]  = 0;
        end
    endtask

    // Modes: 0 steady, 1 M_READY low rel 5..8, 2 stray Start at 8, 3 reset at 9,
    // 4 TVALID toggling, 5 random traffic.
    task automatic applyStimulus(input int mode, input int rel);
        start  = (rel == 0);
        tvalid = 1'b1;
        mready = 1'b1;
        case (mode)
            1: mready = !(rel >= 5 && rel <= 8);
            2: if (rel == 8) start = 1'b1;
            3: rst = (rel == 9 || rel == 10);
            4: tvalid = (rel % 2 == 1);
            5: begin
                tvalid = ($urandom_range(0, 3) != 0);
                mready = ($urandom_range(0, 2) != 0);
                if (rel == 8 && $urandom_range(0, 1) == 1) start = 1'b1;
            end
            default: ;
        endcase
        if (rst) winQ.delete();
    endtask

    task automatic runFrame(input int mode);
        int rel;
        bit allIdle;
        rel = 0;
        forever begin
            @(posedge clk);
            #1;
            applyStimulus(mode, rel);
            for (int i = 0; i < NDUT; i++) computeExpected(i);
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) checkOutput(i);
            for (int i = 0; i < NDUT; i++) advanceModel(i);
            rel++;
            allIdle = 1'b1;
            for (int i = 0; i < NDUT; i++) if (mActive[i] || mDone[i]) allIdle = 1'b0;
            if (rel > 1 && allIdle && !rst) break;
            if (rel >= 400) begin
                compareValue("frame_timeout", mode, rel, 0);
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) computeExpected(i);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) checkOutput(i);
        @(posedge clk);
        #1;
        rst = 1'b0;

        runFrame(0);
        runFrame(1);
        runFrame(2);
        runFrame(3);
        runFrame(0);
        runFrame(4);
        repeat (6) runFrame(5);

        start  = 1'b0;
        tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compareValue("win_queue_drained", 0, winQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
